// File: rtl/approx_adder_err_monitor_if.sv
// Operand/result stream bundle for approx_adder_err_monitor.
// master = operand source / result sink, slave = the adder.
interface approx_adder_err_monitor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic [WIDTH:0]   out_sum;
  logic [WIDTH:0]   out_err;

  modport master (
    output in_valid, in_a, in_b, in_last,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last,
    output in_ready, out_valid, out_sum, out_err
  );
endinterface

// File: rtl/approx_adder_err_monitor.sv
// Two-stage approximate adder (low APPROX_BITS of the sum zeroed) with run statistics.
// Optional macro ERR_MSE_EN adds the saturating squared-error accumulator err_sq_sum.
module approx_adder_err_monitor #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 16,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  approx_adder_err_monitor_if.slave     bus,
  output logic                          done,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [CNT_W-1:0]              err_sum,
  output logic [WIDTH:0]                err_max
`ifdef ERR_MSE_EN
  ,
  output logic [2*CNT_W-1:0]            err_sq_sum
`endif
);

  localparam int SUM_W = ((CNT_W > WIDTH + 1) ? CNT_W : WIDTH + 1) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             accept;
  logic             clear_stats;
  logic             s1_valid_reg;
  logic [WIDTH:0]   s1_exact_reg;
  logic             out_valid_reg;
  logic [WIDTH:0]   out_sum_reg, out_err_reg;
  logic [WIDTH:0]   approx_mask;
  logic [WIDTH:0]   stage_sum, stage_err;

  logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] err_sum_reg, err_sum_next;
  logic [WIDTH:0]   err_max_reg, err_max_next;
  logic [SUM_W-1:0] err_sum_wide;

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_mask
    assign approx_mask[gi] = (gi < APPROX_BITS);
  end

  assign bus.in_ready = (state_reg == RUN);
  assign accept       = bus.in_valid && (state_reg == RUN);
  assign clear_stats  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign stage_sum    = s1_exact_reg & ~approx_mask;
  assign stage_err    = s1_exact_reg & approx_mask;
  assign err_sum_wide = SUM_W'(err_sum_reg) + SUM_W'(stage_err);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && bus.in_last) state_next = DRAIN;
      // stage 2 drains from stage 1, so an empty stage 1 means the last result is out now
      DRAIN:   if (!s1_valid_reg) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_exact_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_err_reg   <= '0;
    end else begin
      s1_valid_reg  <= accept;
      out_valid_reg <= s1_valid_reg;
      if (accept) s1_exact_reg <= {1'b0, bus.in_a} + {1'b0, bus.in_b};
      if (s1_valid_reg) begin
        out_sum_reg <= stage_sum;
        out_err_reg <= stage_err;
      end
    end
  end

  always_comb begin
    sample_cnt_next = sample_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    err_sum_next    = err_sum_reg;
    err_max_next    = err_max_reg;
    if (clear_stats) begin
      sample_cnt_next = '0;
      err_cnt_next    = '0;
      err_sum_next    = '0;
      err_max_next    = '0;
    end else if (s1_valid_reg) begin
      if (!(&sample_cnt_reg)) sample_cnt_next = sample_cnt_reg + CNT_W'(1);
      if ((stage_err != '0) && !(&err_cnt_reg)) err_cnt_next = err_cnt_reg + CNT_W'(1);
      err_sum_next = (|err_sum_wide[SUM_W-1:CNT_W]) ? '1 : err_sum_wide[CNT_W-1:0];
      if (stage_err > err_max_reg) err_max_next = stage_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_reg <= '0;
      err_cnt_reg    <= '0;
      err_sum_reg    <= '0;
      err_max_reg    <= '0;
    end else begin
      sample_cnt_reg <= sample_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      err_sum_reg    <= err_sum_next;
      err_max_reg    <= err_max_next;
    end
  end

`ifdef ERR_MSE_EN
  localparam int SQ_IN_W = 2 * WIDTH + 2;
  localparam int SQ_W    = ((2 * CNT_W > SQ_IN_W) ? 2 * CNT_W : SQ_IN_W) + 1;

  logic [SQ_IN_W-1:0]   err_sq;
  logic [SQ_W-1:0]      err_sq_wide;
  logic [2*CNT_W-1:0]   err_sq_sum_reg, err_sq_sum_next;

  assign err_sq      = SQ_IN_W'(stage_err) * SQ_IN_W'(stage_err);
  assign err_sq_wide = SQ_W'(err_sq_sum_reg) + SQ_W'(err_sq);

  always_comb begin
    err_sq_sum_next = err_sq_sum_reg;
    if (clear_stats) err_sq_sum_next = '0;
    else if (s1_valid_reg)
      err_sq_sum_next = (|err_sq_wide[SQ_W-1:2*CNT_W]) ? '1 : err_sq_wide[2*CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_sq_sum_reg <= '0;
    else     err_sq_sum_reg <= err_sq_sum_next;
  end

  assign err_sq_sum = err_sq_sum_reg;
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_err   = out_err_reg;
  assign done          = (state_reg == DONE);
  assign sample_cnt    = sample_cnt_reg;
  assign err_cnt       = err_cnt_reg;
  assign err_sum       = err_sum_reg;
  assign err_max       = err_max_reg;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Lock-step bench: four adder configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_approx_adder_err_monitor;

  localparam int W  = 16;
  localparam int NC = 4;
  localparam int AB_T [NC] = '{16, 4, 0, 4};
  localparam int CW_T [NC] = '{32, 32, 32, 4};

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           c;
  } pair_t;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         start    = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last  = 1'b0;
  logic [W-1:0] in_a     = '0;
  logic [W-1:0] in_b     = '0;

  logic         o_valid [NC];
  logic         o_ready [NC];
  logic         o_done  [NC];
  logic [W:0]   o_sum   [NC];
  logic [W:0]   o_err   [NC];
  logic [W:0]   o_emax  [NC];
  logic [63:0]  o_cnt   [NC];
  logic [63:0]  o_ecnt  [NC];
  logic [63:0]  o_esum  [NC];
`ifdef ERR_MSE_EN
  logic [127:0] o_sq    [NC];
`endif

  int           checks  = 0;
  int           errors  = 0;
  int           cyc     = 0;
  pair_t        q[$];
  logic [W-1:0] pa[$];
  logic [W-1:0] pb[$];
  logic [127:0] m_cnt [NC];
  logic [127:0] m_ecnt[NC];
  logic [127:0] m_esum[NC];
  logic [127:0] m_emax[NC];
  logic [127:0] m_sq  [NC];
  bit           exp_ready = 1'b0;
  int           done_at   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NC; gi++) begin : g_dut
    localparam int CW = CW_T[gi];
    approx_adder_err_monitor_if #(.WIDTH(W)) bus ();
    logic [CW-1:0] sc, ec, es;
`ifdef ERR_MSE_EN
    logic [2*CW-1:0] sq;
    assign o_sq[gi] = 128'(sq);
`endif
    assign bus.in_valid = in_valid;
    assign bus.in_a     = in_a;
    assign bus.in_b     = in_b;
    assign bus.in_last  = in_last;

    approx_adder_err_monitor #(
      .WIDTH(W), .APPROX_BITS(AB_T[gi]), .CNT_W(CW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .done       (o_done[gi]),
      .sample_cnt (sc),
      .err_cnt    (ec),
      .err_sum    (es),
      .err_max    (o_emax[gi])
`ifdef ERR_MSE_EN
      ,
      .err_sq_sum (sq)
`endif
    );

    assign o_valid[gi] = bus.out_valid;
    assign o_ready[gi] = bus.in_ready;
    assign o_sum[gi]   = bus.out_sum;
    assign o_err[gi]   = bus.out_err;
    assign o_cnt[gi]   = 64'(sc);
    assign o_ecnt[gi]  = 64'(ec);
    assign o_esum[gi]  = 64'(es);
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic string tg(input int k, input string name);
    return $sformatf("cfg%0d_%s@cyc%0d", k, name, cyc);
  endfunction

  function automatic logic [127:0] sat(input logic [127:0] v, input int bits);
    logic [127:0] top;
    top = (128'd1 << bits) - 128'd1;
    return (v > top) ? top : v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NC; k++) begin
      m_cnt[k] = '0; m_ecnt[k] = '0; m_esum[k] = '0; m_emax[k] = '0; m_sq[k] = '0;
    end
  endtask

  task automatic check_stats(input int k);
    check(tg(k, "sample_cnt"), 128'(o_cnt[k]),  m_cnt[k]);
    check(tg(k, "err_cnt"),    128'(o_ecnt[k]), m_ecnt[k]);
    check(tg(k, "err_sum"),    128'(o_esum[k]), m_esum[k]);
    check(tg(k, "err_max"),    128'(o_emax[k]), m_emax[k]);
`ifdef ERR_MSE_EN
    check(tg(k, "err_sq_sum"), o_sq[k], m_sq[k]);
`endif
  endtask

  // One cycle: move to the next falling edge and compare every configuration.
  task automatic tick();
    bit           exp_v;
    pair_t        p;
    logic [127:0] exact, e_err, e_sum;
    @(negedge clk);
    cyc++;
    exp_v = (q.size() > 0) && (q[0].c + 2 == cyc);
    if (exp_v) p = q.pop_front();
    for (int k = 0; k < NC; k++) begin
      check(tg(k, "out_valid"), 128'(o_valid[k]), 128'(exp_v));
      check(tg(k, "in_ready"),  128'(o_ready[k]), 128'(exp_ready));
      check(tg(k, "done"),      128'(o_done[k]),  128'((done_at != 0) && (cyc >= done_at)));
      if (exp_v) begin
        exact = 128'(p.a) + 128'(p.b);
        e_err = exact % (128'd1 << AB_T[k]);
        e_sum = exact - e_err;
        check(tg(k, "out_sum"), 128'(o_sum[k]), e_sum);
        check(tg(k, "out_err"), 128'(o_err[k]), e_err);
        m_cnt[k]  = sat(m_cnt[k] + 128'd1, CW_T[k]);
        if (e_err != 0) m_ecnt[k] = sat(m_ecnt[k] + 128'd1, CW_T[k]);
        m_esum[k] = sat(m_esum[k] + e_err, CW_T[k]);
        if (e_err > m_emax[k]) m_emax[k] = e_err;
        m_sq[k]   = sat(m_sq[k] + e_err * e_err, 2 * CW_T[k]);
      end
      check_stats(k);
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < NC; k++) begin
      check(tg(k, {tag, "_out_valid"}), 128'(o_valid[k]), 128'd0);
      check(tg(k, {tag, "_out_sum"}),   128'(o_sum[k]),   128'd0);
      check(tg(k, {tag, "_out_err"}),   128'(o_err[k]),   128'd0);
      check(tg(k, {tag, "_done"}),      128'(o_done[k]),  128'd0);
      check(tg(k, {tag, "_in_ready"}),  128'(o_ready[k]), 128'd0);
      check_stats(k);
    end
  endtask

  task automatic do_start();
    in_valid  = 1'b0;
    start     = 1'b1;
    exp_ready = 1'b1;
    done_at   = 0;
    clear_model();
    tick();
    start = 1'b0;
  endtask

  task automatic add_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    pa.push_back(a);
    pb.push_back(b);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      // odd + even keeps the low sum bit set, so every approximating config sees an error
      add_pair(W'($urandom) | W'(1), W'($urandom) & ~W'(1));
    end
  endtask

  task automatic send_pairs(input bit gaps, input bit mid_start);
    int n;
    int i;
    int guard;
    n = pa.size();
    i = 0;
    guard = 0;
    while ((i < n) && (guard < 1000)) begin
      guard++;
      start = mid_start && (i == n / 2);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_a     = pa[i];
        in_b     = pb[i];
        in_last  = (i == n - 1);
        q.push_back('{a: pa[i], b: pb[i], c: cyc});
        if (i == n - 1) begin
          exp_ready = 1'b0;
          done_at   = cyc + 3;
        end
        i++;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    pa.delete();
    pb.delete();
  endtask

  task automatic run(input bit gaps, input bit mid_start);
    do_start();
    send_pairs(gaps, mid_start);
    repeat (4) tick();
  endtask

  initial begin
    clear_model();
    #2 rst = 1'b1;
    #1 reset_checks("por");
    tick();
    tick();
    rst = 1'b0;
    tick();

    add_pair(16'hFFFF, 16'h0001);
    run(1'b0, 1'b0);

    add_pair(16'h1234, 16'h0001);
    add_pair(16'h8000, 16'h8000);
    run(1'b0, 1'b0);

    add_pair(16'h0007, 16'h000A);
    run(1'b0, 1'b0);

    add_random(8);
    run(1'b0, 1'b0);

    add_random(20);
    run(1'b1, 1'b1);

    add_random(6);
    run(1'b1, 1'b0);

    // reset with two pairs still inside the pipeline
    do_start();
    in_valid = 1'b1;
    in_a = W'($urandom) | W'(1);
    in_b = W'($urandom);
    q.push_back('{a: in_a, b: in_b, c: cyc});
    tick();
    in_a = W'($urandom) | W'(1);
    in_b = W'($urandom);
    q.push_back('{a: in_a, b: in_b, c: cyc});
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    q.delete();
    exp_ready = 1'b0;
    done_at   = 0;
    clear_model();
    #1 reset_checks("midrst");
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    add_random(3);
    run(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_adder_err_monitor.md
# approx_adder_err_monitor

Parametrised, pipelined approximate adder with an on-line error-statistics engine. It takes a stream of operand pairs and adds them with a full carry chain. It zeroes the `APPROX_BITS` least-significant sum bits, emits the approximate sum with its error, and accumulates run statistics (sample count, error count, error sum, max error). It sits in the error-evaluation datapath between the operand stimulus source and the metrics readout, and supersedes the fixed 16-bit, carry-only approximate adders.

## Interface
Parameters:
- `WIDTH`, 16, operand width in bits; legal range ≥ 1.
- `APPROX_BITS`, 16, number of sum LSBs forced to zero; legal range 0..`WIDTH`.
- `CNT_W`, 32, width of all statistics counters and accumulators.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; clears statistics and begins a run.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts operands.
- `in_a`  in  `WIDTH`  operand A.
- `in_b`  in  `WIDTH`  operand B.
- `in_last`  in  1  marks the final pair of a run.
- `out_valid`  out  1  result valid, one-cycle pulse per accepted pair.
- `out_sum`  out  `WIDTH`+1  approximate sum, including carry-out.
- `out_err`  out  `WIDTH`+1  exact sum minus approximate sum.
- `done`  out  1  high while in DONE.
- `sample_cnt`  out  `CNT_W`  accepted pairs in the run.
- `err_cnt`  out  `CNT_W`  pairs with nonzero error.
- `err_sum`  out  `CNT_W`  sum of `out_err`.
- `err_max`  out  `WIDTH`+1  maximum `out_err`.

## Operation
Arithmetic:
- exact = `in_a` + `in_b`, computed at `WIDTH`+1 bits.
- `out_sum` = exact with bits [`APPROX_BITS`-1:0] cleared. The upper bits and carry-out are exact.
- `out_err` = exact[`APPROX_BITS`-1:0], zero-extended; it is always ≥ 0.
- With `APPROX_BITS`=0, `out_err` is always 0.
- With `APPROX_BITS`=`WIDTH`, only the carry-out bit of `out_sum` is nonzero.

FSM states IDLE, RUN, DRAIN, DONE:
- IDLE → RUN on `start`.
- RUN → DRAIN on the cycle a pair with `in_last`=1 is accepted.
- DRAIN → DONE when the pipeline holds no valid stage.
- DONE → RUN on `start`.
- `start` in RUN or DRAIN is ignored.
- `in_ready` = (state == RUN). There is no output backpressure.

Statistics:
- On `start`, all statistics clear to 0 in the same cycle the state moves to RUN.
- At stage 2, each valid pair updates the statistics:
  - `sample_cnt` += 1.
  - `err_cnt` += (`out_err` ≠ 0).
  - `err_sum` += `out_err`.
  - `err_max` = max(`err_max`, `out_err`).
- All counters saturate at all-ones and never wrap.
- Statistics hold their values in DONE and IDLE.

## Timing
- Reset values: state IDLE; `in_ready`, `out_valid`, `done` 0; `out_sum`, `out_err` 0; all statistics 0. Reset mid-run discards the pipeline contents.
- Accept occurs on a `clk` edge with `in_valid` && `in_ready`.
- Stage 1 registers exact.
- Stage 2 registers `out_sum` and `out_err`, asserts `out_valid`, and updates the statistics.
- Latency: `out_valid` is high exactly 2 cycles after the accept edge. Throughput is 1 pair per cycle.
- Statistics reflect a pair on the same edge that `out_valid` rises for it.
- DRAIN lasts 2 cycles after the last accept, then `done` rises. `done` is asserted in the cycle after the final `out_valid` pulse.
- A `start` pulse coinciding with a stage-2 update in DONE cannot occur, because the pipeline is empty in DONE.

## Configuration
- Macro `ERR_MSE_EN`.
- Defined:
  - Adds output port `err_sq_sum` of width 2*`CNT_W`, which accumulates `out_err`² and saturates.
  - Its reset and `start` value is 0.
  - The squaring is computed at stage 2, so latency is unchanged.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults (16/16): `start`, then (0xFFFF, 0x0001, last). Required: `out_sum`=0x10000, `out_err`=0, `err_cnt`=0, `done` high 3 cycles after the accept.
- Defaults: (0x1234, 0x0001), then (0x8000, 0x8000, last). Required: errors 0x1235 and 0 with sums 0x00000 and 0x10000; `sample_cnt`=2, `err_cnt`=1, `err_sum`=0x1235, `err_max`=0x1235.
- `APPROX_BITS`=4: (0x0007, 0x000A). Required: `out_sum`=0x00010, `out_err`=1. With `ERR_MSE_EN`, `err_sq_sum`=1.
- Back-to-back stream of 8 pairs with `in_valid` held high. Required: 8 consecutive `out_valid` pulses, each 2 cycles after its accept; `in_ready` low from the cycle after the `in_last` accept.
- Assert `rst` in RUN with 2 pairs in flight. Required: all outputs 0 immediately, no `out_valid` pulse, state IDLE.
- `CNT_W`=4 with 20 pairs of nonzero error. Required: `sample_cnt` and `err_cnt` hold at 0xF; a second `start` clears all statistics to 0.
